// File: rtl/mips_pkg.sv
// Shared register-file definitions for the writeback path: default widths,
// the hardwired-zero register index and the result entry type.
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for load/multi-cycle results; also exposes which slots hold
// live entries and their destination registers for the busy-bit compare.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    push_i,
  input  logic [ADDR_W-1:0]       push_rd_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [ADDR_W-1:0]       head_rd_o,
  output logic [DATA_W-1:0]       head_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DEPTH-1:0]        ent_vld_o,
  output logic [DEPTH*ADDR_W-1:0] ent_rd_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              do_push, do_pop;
  logic [PTR_W-1:0]  off;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: liveness is tracked purely by the pointers and count.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_rd_o   = rd_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    ent_vld_o = '0;
    ent_rd_o  = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr_q;
      ent_vld_o[i] = ({1'b0, off} < cnt_q);
      ent_rd_o[i*ADDR_W +: ADDR_W] = rd_mem[i];
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write master: ALU results win the single write slot, loads are
// queued in wb_fifo. Optional stall counter enabled by WB_STALL_CNT_EN.
module writeback_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluRd,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemRd,
  input  logic [DATA_W-1:0] MemData,
  input  logic [ADDR_W-1:0] QryRs,
  input  logic [ADDR_W-1:0] QryRt,
  output logic              RsBusy,
  output logic              RtBusy,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]       StallCnt
`endif
);

  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic                    fifo_full, fifo_empty, push, pop;
  logic [ADDR_W-1:0]       head_rd;
  logic [DATA_W-1:0]       head_data;
  logic [DEPTH-1:0]        ent_vld;
  logic [DEPTH*ADDR_W-1:0] ent_rd;
  logic [ADDR_W-1:0]       wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic                    we_q, we_d;

  // Writes to the zero register complete the handshake but are never queued.
  assign MemReady = ~fifo_full;
  assign push     = MemValid & ~fifo_full & (MemRd != RZ);
  assign pop      = ~AluValid & ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .push_i      (push),
    .push_rd_i   (MemRd),
    .push_data_i (MemData),
    .pop_i       (pop),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .ent_vld_o   (ent_vld),
    .ent_rd_o    (ent_rd)
  );

  always_comb begin
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    if (AluValid) begin
      wr_reg_d  = AluRd;
      wr_data_d = AluData;
      we_d      = (AluRd != RZ);
    end else if (!fifo_empty) begin
      wr_reg_d  = head_rd;
      wr_data_d = head_data;
      we_d      = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
    end else begin
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      we_q      <= we_d;
    end
  end

  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign RegWrite      = we_q;

  function automatic logic reg_busy(input logic [ADDR_W-1:0]       q,
                                    input logic [DEPTH-1:0]        vld,
                                    input logic [DEPTH*ADDR_W-1:0] rds,
                                    input logic                    we,
                                    input logic [ADDR_W-1:0]       wr);
    logic hit;
    hit = we & (wr == q);
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (vld[i] & (rds[i*ADDR_W +: ADDR_W] == q));
    return (q != RZ) & hit;
  endfunction

  assign RsBusy = reg_busy(QryRs, ent_vld, ent_rd, we_q, wr_reg_q);
  assign RtBusy = reg_busy(QryRt, ent_vld, ent_rd, we_q, wr_reg_q);

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (AluValid && !fifo_empty && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule
